// File: rtl/posit_bridge_pkg.sv
// Shared constants and types for the posit operation bridge: register map,
// CTRL/STATUS bit positions and the issue/wait state machine encoding.
package posit_bridge_pkg;

   localparam logic [3:0] ADDR_CTRL   = 4'd8;
   localparam logic [3:0] ADDR_STATUS = 4'd9;
   localparam logic [3:0] ADDR_RESULT = 4'd10;
   localparam logic [3:0] ADDR_FLAGS  = 4'd11;
   localparam logic [3:0] ADDR_COUNT  = 4'd12;

   localparam int CTRL_START      = 0;
   localparam int CTRL_OPCODE_LSB = 4;
   localparam int CTRL_IRQ_EN     = 8;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TIMEOUT = 2;
   localparam int STAT_OVERRUN = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } bridge_state_e;

endpackage

// File: rtl/posit_bridge_csr.sv
// Avalon-MM register file for the posit bridge: operand/opcode storage,
// sticky status with write-1-to-clear, result capture, 1-cycle read path.
module posit_bridge_csr
   import posit_bridge_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int NUM_OPERANDS = 3,
   parameter int OP_W         = 4,
   parameter int FLAG_W       = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [3:0]                    address,
   input  logic                          read,
   input  logic                          write,
   input  logic [31:0]                   writedata,
   output logic [31:0]                   readdata,
   output logic                          readdatavalid,
   input  logic                          busy,
   input  logic                          done_set,
   input  logic                          timeout_set,
   input  logic [WIDTH-1:0]              res_data,
   input  logic [FLAG_W-1:0]             res_flags,
   output logic                          start,
   output logic [OP_W-1:0]               opcode,
   output logic [NUM_OPERANDS*WIDTH-1:0] operands,
   output logic                          irq
);

   logic [WIDTH-1:0]  operand_q [NUM_OPERANDS];
   logic [OP_W-1:0]   opcode_q;
   logic              irq_en_q;
   logic              done_q;
   logic              timeout_q;
   logic              overrun_q;
   logic [WIDTH-1:0]  result_q;
   logic [FLAG_W-1:0] flags_q;
   logic [31:0]       count_q;
   logic              irq_q;
   logic [31:0]       readdata_q;
   logic              readdatavalid_q;
   logic [31:0]       rd_mux;

   logic wr_ctrl;
   logic wr_status;
   logic start_hit;

   assign wr_ctrl   = write && (address == ADDR_CTRL);
   assign wr_status = write && (address == ADDR_STATUS);
   assign start_hit = wr_ctrl && writedata[CTRL_START];
   assign start     = start_hit && !busy;

   // Operands are frozen for the whole operation so the core sees stable data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OPERANDS; i++) operand_q[i] <= '0;
      end else if (write && !busy) begin
         for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (address == 4'(i)) operand_q[i] <= writedata[WIDTH-1:0];
         end
      end
   end

   // Sticky status bits: a set event in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q  <= '0;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
         count_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            irq_en_q <= writedata[CTRL_IRQ_EN];
            if (!busy) opcode_q <= writedata[CTRL_OPCODE_LSB +: OP_W];
         end
         done_q    <= done_set    | (done_q    & ~(wr_status & writedata[STAT_DONE]));
         timeout_q <= timeout_set | (timeout_q & ~(wr_status & writedata[STAT_TIMEOUT]));
         overrun_q <= (start_hit & busy) | (overrun_q & ~(wr_status & writedata[STAT_OVERRUN]));
         if (done_set) begin
            result_q <= res_data;
            flags_q  <= res_flags;
            count_q  <= count_q + 32'd1;
         end
         irq_q <= irq_en_q & (done_q | timeout_q);
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
         if (address == 4'(i)) rd_mux[WIDTH-1:0] = operand_q[i];
      end
      case (address)
         ADDR_CTRL: begin
            rd_mux[CTRL_OPCODE_LSB +: OP_W] = opcode_q;
            rd_mux[CTRL_IRQ_EN]             = irq_en_q;
         end
         ADDR_STATUS: begin
            rd_mux[STAT_BUSY]    = busy;
            rd_mux[STAT_DONE]    = done_q;
            rd_mux[STAT_TIMEOUT] = timeout_q;
            rd_mux[STAT_OVERRUN] = overrun_q;
         end
         ADDR_RESULT: rd_mux[WIDTH-1:0]  = result_q;
         ADDR_FLAGS:  rd_mux[FLAG_W-1:0] = flags_q;
         ADDR_COUNT:  rd_mux             = count_q;
         default: ;
      endcase
   end

   // The mux samples pre-write state, so a read colliding with a write sees the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
      end else begin
         readdatavalid_q <= read;
         if (read) readdata_q <= rd_mux;
      end
   end

   for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_pack
      assign operands[g*WIDTH +: WIDTH] = operand_q[g];
   end

   assign opcode        = opcode_q;
   assign irq           = irq_q;
   assign readdata      = readdata_q;
   assign readdatavalid = readdatavalid_q;

endmodule

// File: rtl/posit_op_bridge.sv
// CSR bridge between the lightweight H2F bus and the posit core: issues one
// operation at a time, waits for the result under a timeout watchdog.
module posit_op_bridge
   import posit_bridge_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int NUM_OPERANDS = 3,
   parameter int OP_W         = 4,
   parameter int FLAG_W       = 4,
   parameter int TIMEOUT      = 1024
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic [3:0]                    avs_address,
   input  logic                          avs_read,
   input  logic                          avs_write,
   input  logic [31:0]                   avs_writedata,
   output logic [31:0]                   avs_readdata,
   output logic                          avs_readdatavalid,
   output logic                          op_valid,
   input  logic                          op_ready,
   output logic [OP_W-1:0]               op_code,
   output logic [NUM_OPERANDS*WIDTH-1:0] op_operands,
   input  logic                          res_valid,
   input  logic [WIDTH-1:0]              res_data,
   input  logic [FLAG_W-1:0]             res_flags,
   output logic                          irq
);

   localparam int              CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   bridge_state_e    state_q;
   bridge_state_e    state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             start;
   logic             busy;
   logic             done_set;
   logic             timeout_set;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake valid/ready: op_valid rises on an accepted START and holds,
   // with op_code/op_operands frozen, until the cycle op_ready is seen high.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      done_set    = 1'b0;
      timeout_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = ISSUE;
         end
         ISSUE: begin
            if (op_ready) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A result arriving on the expiry cycle takes priority over the watchdog.
            if (res_valid) begin
               done_set = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_set = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign op_valid = (state_q == ISSUE);

   posit_bridge_csr #(
      .WIDTH        (WIDTH),
      .NUM_OPERANDS (NUM_OPERANDS),
      .OP_W         (OP_W),
      .FLAG_W       (FLAG_W)
   ) u_csr (
      .clk           (clk_clk),
      .rst_n         (reset_reset_n),
      .address       (avs_address),
      .read          (avs_read),
      .write         (avs_write),
      .writedata     (avs_writedata),
      .readdata      (avs_readdata),
      .readdatavalid (avs_readdatavalid),
      .busy          (busy),
      .done_set      (done_set),
      .timeout_set   (timeout_set),
      .res_data      (res_data),
      .res_flags     (res_flags),
      .start         (start),
      .opcode        (op_code),
      .operands      (op_operands),
      .irq           (irq)
   );

endmodule
